// File: rtl/adc_bcd_display.sv
// Samples an 8-bit ADC word, box-car averages 2^AVG_LOG2 samples and converts
// the average to three BCD digits for a 4-digit seven-segment driver.
module adc_bcd_display #(
  parameter int SAMPLE_DIV = 48000,
  parameter int AVG_LOG2   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] adc_data,
  input  logic       hold,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic [3:0] num4,
  output logic [7:0] adc_avg,
  output logic       upd,
  output logic       ovr
);

  localparam int TCNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SCNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int ACC_W  = 8 + AVG_LOG2;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(SAMPLE_DIV - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [7:0]        adc_avg_q, adc_avg_d;
  logic [19:0]       sr_q, sr_d;
  logic [2:0]        iter_q, iter_d;
  logic [11:0]       digits_q, digits_d;
  logic              upd_q, upd_d;
  logic              ovr_q, ovr_d;
  logic [3:0]        num4_q, num4_d;

  logic              tick;
  logic              last_sample;
  logic              avg_valid;
  logic [ACC_W-1:0]  sum;
  logic [7:0]        avg;

  // One double-dabble step: correct each BCD nibble, then shift left by one.
  function automatic logic [19:0] dabble(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int i = 0; i < 3; i++) begin
      if (t[8 + 4*i +: 4] >= 4'd5) begin
        t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
      end
    end
    return {t[18:0], 1'b0};
  endfunction

  always_comb begin
    tick   = (tcnt_q == TCNT_LAST);
    tcnt_d = tcnt_q + 1'b1;
    if (tick) begin
      tcnt_d = '0;
    end
  end

  // The accumulator is wide enough for 2^AVG_LOG2 full-scale samples.
  always_comb begin
    last_sample = (scnt_q == SCNT_LAST);
    avg_valid   = tick && last_sample;
    sum         = acc_q + ACC_W'(adc_data);
    avg         = sum[AVG_LOG2 +: 8];
    acc_d       = acc_q;
    scnt_d      = scnt_q;
    adc_avg_d   = adc_avg_q;
    if (tick) begin
      if (last_sample) begin
        acc_d     = '0;
        scnt_d    = '0;
        adc_avg_d = avg;
      end else begin
        acc_d  = sum;
        scnt_d = scnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    iter_d   = iter_q;
    digits_d = digits_q;
    upd_d    = 1'b0;
    ovr_d    = ovr_q;
    if (avg_valid && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (avg_valid) begin
          sr_d    = {12'b0, avg};
          iter_d  = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d   = dabble(sr_q);
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // A held display simply discards the finished conversion.
        if (!hold) begin
          digits_d = sr_q[19:8];
          upd_d    = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    num4_d = hold ? 4'hA : 4'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      scnt_q    <= '0;
      acc_q     <= '0;
      adc_avg_q <= '0;
      sr_q      <= '0;
      iter_q    <= '0;
      digits_q  <= '0;
      upd_q     <= 1'b0;
      ovr_q     <= 1'b0;
      num4_q    <= '0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      scnt_q    <= scnt_d;
      acc_q     <= acc_d;
      adc_avg_q <= adc_avg_d;
      sr_q      <= sr_d;
      iter_q    <= iter_d;
      digits_q  <= digits_d;
      upd_q     <= upd_d;
      ovr_q     <= ovr_d;
      num4_q    <= num4_d;
    end
  end

  assign num1    = digits_q[3:0];
  assign num2    = digits_q[7:4];
  assign num3    = digits_q[11:8];
  assign num4    = num4_q;
  assign adc_avg = adc_avg_q;
  assign upd     = upd_q;
  assign ovr     = ovr_q;

endmodule

// File: tb/tb_adc_bcd_display.sv
// Directed bench: instance A (SAMPLE_DIV=4, AVG_LOG2=2) for averaging/display,
// instance B (SAMPLE_DIV=1, AVG_LOG2=1) for the overrun path.
module tb_adc_bcd_display;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, hold_a;
  logic [7:0] adc_a;
  logic [3:0] num1_a, num2_a, num3_a, num4_a;
  logic [7:0] adc_avg_a;
  logic       upd_a, ovr_a;

  logic       rst_b, hold_b;
  logic [7:0] adc_b;
  logic [3:0] num1_b, num2_b, num3_b, num4_b;
  logic [7:0] adc_avg_b;
  logic       upd_b, ovr_b;

  int checks = 0;
  int passes = 0;
  int upd_cnt_a;
  int upd_cyc_a;
  logic [11:0] dig8_a;

  adc_bcd_display #(.SAMPLE_DIV(4), .AVG_LOG2(2)) dut_a (
    .clk(clk), .rst(rst_a), .adc_data(adc_a), .hold(hold_a),
    .num1(num1_a), .num2(num2_a), .num3(num3_a), .num4(num4_a),
    .adc_avg(adc_avg_a), .upd(upd_a), .ovr(ovr_a)
  );

  adc_bcd_display #(.SAMPLE_DIV(1), .AVG_LOG2(1)) dut_b (
    .clk(clk), .rst(rst_b), .adc_data(adc_b), .hold(hold_b),
    .num1(num1_b), .num2(num2_b), .num3(num3_b), .num4(num4_b),
    .adc_avg(adc_avg_b), .upd(upd_b), .ovr(ovr_b)
  );

  task automatic reset_a();
    rst_a  = 1'b1;
    adc_a  = 8'd0;
    hold_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
  endtask

  // Sixteen cycles = one full average; the last-sample edge is cycle 16.
  task automatic quad_a(input logic [7:0] v0, input logic [7:0] v1,
                        input logic [7:0] v2, input logic [7:0] v3);
    logic [7:0] v [4];
    v = '{v0, v1, v2, v3};
    upd_cnt_a = 0;
    upd_cyc_a = 0;
    dig8_a    = '0;
    for (int c = 1; c <= 16; c++) begin
      adc_a = v[(c-1)/4];
      @(negedge clk);
      if (upd_a) begin
        upd_cnt_a++;
        upd_cyc_a = c;
      end
      if (c == 8) dig8_a = {num3_a, num2_a, num1_a};
    end
  endtask

  task automatic test_reset();
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    adc_a  = 8'hFF;
    adc_b  = 8'hFF;
    hold_a = 1'b1;
    hold_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({num3_a, num2_a, num1_a} !== 12'h000) $display("[TB] FAIL reset_digits: got %h expected 000", {num3_a, num2_a, num1_a});
    else passes++;
    checks++;
    if (num4_a !== 4'h0) $display("[TB] FAIL reset_num4: got %h expected 0", num4_a);
    else passes++;
    checks++;
    if (adc_avg_a !== 8'd0) $display("[TB] FAIL reset_avg: got %0d expected 0", adc_avg_a);
    else passes++;
    checks++;
    if ({upd_a, ovr_a, ovr_b} !== 3'b000) $display("[TB] FAIL reset_flags: got %b expected 000", {upd_a, ovr_a, ovr_b});
    else passes++;
    hold_a = 1'b0;
    rst_a  = 1'b0;
    quad_a(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    checks++;
    if (upd_cnt_a !== 0) $display("[TB] FAIL reset_no_early_upd: got %0d expected 0", upd_cnt_a);
    else passes++;
  endtask

  task automatic test_full_scale();
    reset_a();
    quad_a(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    checks++;
    if (adc_avg_a !== 8'd255) $display("[TB] FAIL fs_avg: got %0d expected 255", adc_avg_a);
    else passes++;
    quad_a(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    checks++;
    if (dig8_a !== 12'h000) $display("[TB] FAIL fs_latency_early: got %h expected 000", dig8_a);
    else passes++;
    checks++;
    if (upd_cnt_a !== 1 || upd_cyc_a !== 9) $display("[TB] FAIL fs_upd: got cnt %0d cyc %0d expected cnt 1 cyc 9", upd_cnt_a, upd_cyc_a);
    else passes++;
    checks++;
    if ({num3_a, num2_a, num1_a} !== 12'h255) $display("[TB] FAIL fs_digits: got %h expected 255", {num3_a, num2_a, num1_a});
    else passes++;
  endtask

  task automatic test_average();
    reset_a();
    quad_a(8'd10, 8'd20, 8'd30, 8'd40);
    checks++;
    if (adc_avg_a !== 8'd25) $display("[TB] FAIL avg_25: got %0d expected 25", adc_avg_a);
    else passes++;
    quad_a(8'd1, 8'd1, 8'd1, 8'd2);
    checks++;
    if (adc_avg_a !== 8'd1) $display("[TB] FAIL avg_trunc: got %0d expected 1", adc_avg_a);
    else passes++;
    checks++;
    if (upd_cnt_a !== 1 || {num3_a, num2_a, num1_a} !== 12'h025) $display("[TB] FAIL avg_digits_25: got %h cnt %0d expected 025 cnt 1", {num3_a, num2_a, num1_a}, upd_cnt_a);
    else passes++;
    quad_a(8'd0, 8'd0, 8'd0, 8'd0);
    checks++;
    if (upd_cnt_a !== 1 || {num3_a, num2_a, num1_a} !== 12'h001) $display("[TB] FAIL avg_digits_1: got %h cnt %0d expected 001 cnt 1", {num3_a, num2_a, num1_a}, upd_cnt_a);
    else passes++;
  endtask

  task automatic test_hold();
    reset_a();
    quad_a(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    quad_a(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    hold_a = 1'b1;
    quad_a(8'd0, 8'd0, 8'd0, 8'd0);
    checks++;
    if (adc_avg_a !== 8'd0) $display("[TB] FAIL hold_avg: got %0d expected 0", adc_avg_a);
    else passes++;
    checks++;
    if (num4_a !== 4'hA) $display("[TB] FAIL hold_num4: got %h expected A", num4_a);
    else passes++;
    quad_a(8'd0, 8'd0, 8'd0, 8'd0);
    checks++;
    if (upd_cnt_a !== 0 || {num3_a, num2_a, num1_a} !== 12'h255) $display("[TB] FAIL hold_frozen: got %h cnt %0d expected 255 cnt 0", {num3_a, num2_a, num1_a}, upd_cnt_a);
    else passes++;
    hold_a = 1'b0;
    quad_a(8'd0, 8'd0, 8'd0, 8'd0);
    checks++;
    if (upd_cnt_a !== 1 || {num3_a, num2_a, num1_a} !== 12'h000) $display("[TB] FAIL hold_release: got %h cnt %0d expected 000 cnt 1", {num3_a, num2_a, num1_a}, upd_cnt_a);
    else passes++;
    checks++;
    if (num4_a !== 4'h0) $display("[TB] FAIL hold_num4_clear: got %h expected 0", num4_a);
    else passes++;
  endtask

  task automatic test_reset_midconv();
    reset_a();
    quad_a(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    quad_a(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_a = 1'b1;
    #1;
    checks++;
    if ({num3_a, num2_a, num1_a, adc_avg_a} !== 20'h0) $display("[TB] FAIL midrst_outputs: got %h expected 00000", {num3_a, num2_a, num1_a, adc_avg_a});
    else passes++;
    repeat (2) @(negedge clk);
    checks++;
    if (upd_a !== 1'b0) $display("[TB] FAIL midrst_upd: got %b expected 0", upd_a);
    else passes++;
    rst_a = 1'b0;
    quad_a(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    checks++;
    if (upd_cnt_a !== 0 || {num3_a, num2_a, num1_a} !== 12'h000) $display("[TB] FAIL midrst_abandon: got %h cnt %0d expected 000 cnt 0", {num3_a, num2_a, num1_a}, upd_cnt_a);
    else passes++;
    quad_a(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    checks++;
    if (upd_cnt_a !== 1 || {num3_a, num2_a, num1_a} !== 12'h255) $display("[TB] FAIL midrst_recover: got %h cnt %0d expected 255 cnt 1", {num3_a, num2_a, num1_a}, upd_cnt_a);
    else passes++;
  endtask

  // Averages land on edges 2,4,6,...; only those on edges 2 and 12 convert.
  task automatic test_overrun();
    int ub;
    ub = 0;
    @(negedge clk);
    rst_b = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      adc_b = (k <= 12) ? 8'(10 * k) : 8'd120;
      @(negedge clk);
      if (upd_b) ub++;
      if (k == 3) begin
        checks++;
        if (ovr_b !== 1'b0) $display("[TB] FAIL ovr_early: got %b expected 0", ovr_b);
        else passes++;
      end
      if (k == 4) begin
        checks++;
        if (ovr_b !== 1'b1 || adc_avg_b !== 8'd35) $display("[TB] FAIL ovr_rise: got ovr %b avg %0d expected ovr 1 avg 35", ovr_b, adc_avg_b);
        else passes++;
      end
      if (k == 11) begin
        checks++;
        if (upd_b !== 1'b1 || {num3_b, num2_b, num1_b} !== 12'h015) $display("[TB] FAIL ovr_first_disp: got %h upd %b expected 015 upd 1", {num3_b, num2_b, num1_b}, upd_b);
        else passes++;
      end
      if (k == 21) begin
        checks++;
        if (upd_b !== 1'b1 || {num3_b, num2_b, num1_b} !== 12'h115) $display("[TB] FAIL ovr_second_disp: got %h upd %b expected 115 upd 1", {num3_b, num2_b, num1_b}, upd_b);
        else passes++;
        checks++;
        if (ovr_b !== 1'b1) $display("[TB] FAIL ovr_sticky: got %b expected 1", ovr_b);
        else passes++;
      end
    end
    checks++;
    if (ub !== 2) $display("[TB] FAIL ovr_upd_count: got %0d expected 2", ub);
    else passes++;
    rst_b = 1'b1;
    #1;
    checks++;
    if (ovr_b !== 1'b0) $display("[TB] FAIL ovr_clear: got %b expected 0", ovr_b);
    else passes++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_average();
    test_hold();
    test_reset_midconv();
    test_overrun();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/adc_bcd_display.md
Name: adc_bcd_display

Overview:
- Consumes the 8-bit `adc_data` word produced by the serial ADC interface block.
- Samples it at a fixed rate and box-car averages 2^AVG_LOG2 samples.
- Converts each average to three BCD digits with a sequential double-dabble FSM.
- Drives the four nibble inputs of the 4-digit seven-segment driver, so the board shows the ADC reading in decimal (000–255).

Parameters:
- SAMPLE_DIV, 48000, clk cycles between samples (1 kHz at 48 MHz); legal range ≥1.
- AVG_LOG2, 4, log2 of samples per average (16); legal range 0..8.

Ports:
- clk  in  1  system clock (48 MHz board clock).
- rst  in  1  reset, asynchronous, active-high.
- adc_data  in  8  latest ADC conversion result; quasi-static, sampled only on tick.
- hold  in  1  level; 1 freezes the displayed digits.
- num1  out  4  ones digit, BCD.
- num2  out  4  tens digit, BCD.
- num3  out  4  hundreds digit, BCD (0..2).
- num4  out  4  status digit: 4'hA while hold=1, else 4'h0.
- adc_avg  out  8  most recent average, binary.
- upd  out  1  one-cycle pulse when num1..num3 change.
- ovr  out  1  sticky overrun flag.

Behaviour:
- Reset: all outputs 0, tick counter 0, accumulator 0, sample count 0, FSM in IDLE. Asserting reset mid-conversion abandons the conversion; no partial update.
- Tick counter: counts 0..SAMPLE_DIV-1 and wraps. tick=1 in the cycle where count==SAMPLE_DIV-1.
- Accumulator: width 8+AVG_LOG2; never overflows. Sample counter counts 0..2^AVG_LOG2-1.
- On a tick that is not the last sample: acc += adc_data; scnt++.
- On the last-sample tick (scnt==2^AVG_LOG2-1), edge T:
  - avg = (acc+adc_data) >> AVG_LOG2, truncating.
  - acc and scnt clear to 0.
  - adc_avg <= avg.
  - If FSM is IDLE: load shift reg {12'b0, avg}, iter=0, go to SHIFT.
  - If FSM is busy: the average is dropped for conversion (adc_avg still updates) and ovr <= 1, held until reset.
- AVG_LOG2=0: every tick is a last-sample tick; avg = adc_data.
- FSM states IDLE → SHIFT → DONE → IDLE.
  - SHIFT: 8 cycles, edges T+1..T+8. Each cycle, every BCD nibble ≥5 gets +3, then the 20-bit register shifts left 1. Leave SHIFT after iter==7.
  - DONE: at edge T+9, if hold=0: num3/num2/num1 <= bcd[11:8]/[7:4]/[3:0] and upd=1 for exactly that one cycle. If hold=1: digits unchanged, upd stays 0. Then go to IDLE.
- Latency: 9 clk from last-sample tick edge to digit update.
- num4 is registered every cycle from hold, with 1-cycle latency, independent of the FSM.
- hold does not stop sampling, averaging, adc_avg or ovr.
- Overrun is reachable only when SAMPLE_DIV·2^AVG_LOG2 < 10; it cannot occur at default parameters.

Test Plan:
- Reset: hold rst=1 with adc_data=8'hFF → num1..num4=0, adc_avg=0, upd=0, ovr=0. After release, no upd until the first full average.
- SAMPLE_DIV=4, AVG_LOG2=2, adc_data=255 constant → at the 4th tick adc_avg=255; 9 clk later num3=2, num2=5, num1=5, upd high exactly 1 cycle.
- Same params, per-tick samples 10, 20, 30, 40 → avg=25, digits 0/2/5. Then samples 1, 1, 1, 2 → avg=1 (truncation), digits 0/0/1.
- hold=1 after showing 255, then adc_data=0 → adc_avg becomes 0, digits stay 2/5/5, num4=4'hA, no upd. Release hold → next average shows 0/0/0 with upd, and num4=0.
- SAMPLE_DIV=1, AVG_LOG2=1, adc_data ramping → ovr rises at the second average while FSM is busy and stays 1; displayed values only come from non-dropped averages. Pulsing rst clears ovr.
- Assert rst at T+4 of a conversion of 255 → outputs 0, no upd. After release, the next full average converts normally.
